// File: rtl/demux4_64b_stream.sv
// ---------------------------------------------------------------------------
// demux4_64b_stream
//
// Routes 64-bit beats from one valid/ready upstream source to one of four
// downstream ports. The destination is taken from in_sel on a packet's first
// beat and held until that packet's last beat, so beats of one packet never
// interleave across ports. Each output port owns a one-entry holding register.
//
// Handshake (valid/ready on both sides): a transfer happens on a rising edge
// where valid and ready are both 1. A source must keep its payload stable
// while valid=1 and ready=0. Ready may depend combinationally on the payload
// and does not wait for valid.
//
// Ports
//   clk, reset  : clock; synchronous active-high reset
//   in_data     : upstream beat (DATA_W)
//   in_sel      : destination port, used on a packet's first beat only
//   in_last     : final beat of packet
//   in_valid    : upstream beat present
//   in_ready    : beat accepted this cycle (combinational)
//   out_data    : packed port data, port p at [p*DATA_W +: DATA_W]
//   out_last    : per-port last flag
//   out_valid   : per-port beat present
//   out_ready   : per-port downstream accept
//   busy        : a packet is locked (state IN_PKT); doubles as FSM state view
//   cur_sel     : locked destination, meaningful while busy=1
//   pkt_cnt     : packed per-port completed-packet counters, CNT_W each
// ---------------------------------------------------------------------------
module demux4_64b_stream #(
    parameter int DATA_W = 64,
    parameter int CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_W-1:0]     in_data,
    input  logic [1:0]            in_sel,
    input  logic                  in_last,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [4*DATA_W-1:0]   out_data,
    output logic [3:0]            out_last,
    output logic [3:0]            out_valid,
    input  logic [3:0]            out_ready,
    output logic                  busy,
    output logic [1:0]            cur_sel,
    output logic [4*CNT_W-1:0]    pkt_cnt
);

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_IN_PKT = 1'b1;

    logic [0:0]          r_state;
    logic [1:0]          r_lock_sel;
    logic [4*DATA_W-1:0] r_out_data;
    logic [3:0]          r_out_last;
    logic [3:0]          r_out_valid;
    logic [4*CNT_W-1:0]  r_pkt_cnt;

    logic [1:0]          w_dest;
    logic                w_ready;
    logic                w_accept;

    // Mid-packet the locked port wins; in_sel only matters on a first beat.
    assign w_dest   = (r_state == S_IN_PKT) ? r_lock_sel : in_sel;
    // The destination slot is free if empty or being drained this edge.
    assign w_ready  = ~r_out_valid[w_dest] | out_ready[w_dest];
    assign w_accept = in_valid & w_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_lock_sel  <= 2'd0;
            r_out_data  <= '0;
            r_out_last  <= '0;
            r_out_valid <= '0;
            r_pkt_cnt   <= '0;
        end else begin
            if (w_accept) begin
                case (r_state)
                    S_IDLE: begin
                        // A single-beat packet never enters IN_PKT.
                        if (!in_last) begin
                            r_state    <= S_IN_PKT;
                            r_lock_sel <= in_sel;
                        end
                    end
                    default: begin
                        if (in_last) begin
                            r_state <= S_IDLE;
                        end
                    end
                endcase
            end

            for (int p = 0; p < 4; p++) begin
                if (w_accept && (w_dest == 2'(p))) begin
                    // A load overrides a same-cycle drain: new beat replaces old.
                    r_out_data[p*DATA_W +: DATA_W] <= in_data;
                    r_out_last[p]                  <= in_last;
                    r_out_valid[p]                 <= 1'b1;
                    if (in_last) begin
                        r_pkt_cnt[p*CNT_W +: CNT_W] <= r_pkt_cnt[p*CNT_W +: CNT_W]
                                                       + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end else if (r_out_valid[p] && out_ready[p]) begin
                    r_out_valid[p] <= 1'b0;
                end
            end
        end
    end

    assign in_ready  = w_ready;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign out_valid = r_out_valid;
    assign busy      = (r_state == S_IN_PKT);
    assign cur_sel   = r_lock_sel;
    assign pkt_cnt   = r_pkt_cnt;

endmodule

// File: tb/tb_demux4_64b_stream.sv
// ---------------------------------------------------------------------------
// tb_demux4_64b_stream
//
// Drives the demux with directed scenarios and random traffic. Expected
// values come from a packet-level reference model (per-port slot contents,
// lock state, packet counts) plus explicit lists of beats each port must
// deliver. The DUT is built with CNT_W=4 so counter wrap is reachable.
// ---------------------------------------------------------------------------
module tb_demux4_64b_stream;

    localparam int DW = 64;
    localparam int CW = 4;

    typedef logic [DW-1:0] beat_q_t[$];

    logic              clk = 1'b0;
    logic              reset;
    logic [DW-1:0]     in_data;
    logic [1:0]        in_sel;
    logic              in_last;
    logic              in_valid;
    logic              in_ready;
    logic [4*DW-1:0]   out_data;
    logic [3:0]        out_last;
    logic [3:0]        out_valid;
    logic [3:0]        out_ready;
    logic              busy;
    logic [1:0]        cur_sel;
    logic [4*CW-1:0]   pkt_cnt;

    always #5 clk = ~clk;

    demux4_64b_stream #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .in_data(in_data), .in_sel(in_sel), .in_last(in_last),
        .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_last(out_last), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy), .cur_sel(cur_sel), .pkt_cnt(pkt_cnt)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: what each port slot holds, and packet lock state.
    logic [DW-1:0] m_data[4];
    logic [3:0]    m_valid;
    logic [3:0]    m_last;
    int            m_cnt[4];
    bit            m_in_pkt;
    int            m_lock;

    // Beats the DUT actually handed downstream: {port, data}.
    logic [DW+1:0] obs_q[$];
    logic [DW-1:0] exp_q[$];

    function automatic int m_dest();
        return m_in_pkt ? m_lock : int'(in_sel);
    endfunction

    function automatic bit m_ready();
        int d;
        d = m_dest();
        return !m_valid[d] || out_ready[d];
    endfunction

    function automatic logic [4*CW-1:0] m_cnt_packed();
        logic [4*CW-1:0] v;
        for (int p = 0; p < 4; p++) v[p*CW +: CW] = CW'(m_cnt[p] % (1 << CW));
        return v;
    endfunction

    function automatic beat_q_t port_obs(int p);
        beat_q_t q;
        foreach (obs_q[k]) if (int'(obs_q[k][DW+1:DW]) == p) q.push_back(obs_q[k][DW-1:0]);
        return q;
    endfunction

    function automatic logic [DW-1:0] port_data(int p);
        return out_data[p*DW +: DW];
    endfunction

    task automatic model_clear();
        for (int p = 0; p < 4; p++) begin
            m_data[p] = '0;
            m_cnt[p]  = 0;
        end
        m_valid  = '0;
        m_last   = '0;
        m_in_pkt = 0;
        m_lock   = 0;
    endtask

    // One clock: record downstream transfers, advance the model, settle.
    task automatic tick();
        int d;
        bit acc;
        d   = m_dest();
        acc = in_valid && m_ready() && !reset;
        if (!reset)
            for (int p = 0; p < 4; p++)
                if (out_valid[p] && out_ready[p]) obs_q.push_back({2'(p), port_data(p)});
        @(posedge clk);
        if (reset) begin
            model_clear();
        end else begin
            for (int p = 0; p < 4; p++) if (m_valid[p] && out_ready[p]) m_valid[p] = 1'b0;
            if (acc) begin
                m_valid[d] = 1'b1;
                m_data[d]  = in_data;
                m_last[d]  = in_last;
                if (in_last) m_cnt[d] = (m_cnt[d] + 1) % (1 << CW);
                if (!m_in_pkt && !in_last) begin
                    m_in_pkt = 1;
                    m_lock   = int'(in_sel);
                end else if (m_in_pkt && in_last) begin
                    m_in_pkt = 0;
                end
            end
        end
        #1;
    endtask

    task automatic drive(input logic [1:0] sel, input logic [DW-1:0] data, input logic last);
        in_valid = 1'b1;
        in_sel   = sel;
        in_data  = data;
        in_last  = last;
        #1;
    endtask

    task automatic idle(input int n);
        in_valid  = 1'b0;
        out_ready = 4'hF;
        repeat (n) tick();
        obs_q.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(2'd3, 64'h1234_5678_9ABC_DEF0, 1'b0);
        out_ready = 4'h0;
        tick();
        tick();
        n_checks++;
        if (out_valid !== 4'b0000) $display("FAIL reset_out_valid got=%b exp=0000", out_valid);
        else n_pass++;
        n_checks++;
        if (busy !== 1'b0 || cur_sel !== 2'd0) $display("FAIL reset_busy_sel got=%b/%0d exp=0/0", busy, cur_sel);
        else n_pass++;
        n_checks++;
        if (pkt_cnt !== '0 || out_last !== 4'b0000 || out_data !== '0)
            $display("FAIL reset_regs cnt=%h last=%b data=%h exp=0", pkt_cnt, out_last, out_data);
        else n_pass++;
        reset    = 1'b0;
        in_valid = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", in_ready);
        else n_pass++;
    endtask

    task automatic test_single_beat();
        idle(2);
        drive(2'd2, 64'hDEADBEEF_00000001, 1'b1);
        tick();
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 4'b0100) $display("FAIL single_out_valid got=%b exp=0100", out_valid);
        else n_pass++;
        n_checks++;
        if (port_data(2) !== 64'hDEADBEEF_00000001 || out_last[2] !== 1'b1)
            $display("FAIL single_data got=%h last=%b exp=deadbeef00000001 last=1", port_data(2), out_last[2]);
        else n_pass++;
        n_checks++;
        if (pkt_cnt[2*CW +: CW] !== 4'd1 || busy !== 1'b0)
            $display("FAIL single_cnt_busy cnt=%0d busy=%b exp=1/0", pkt_cnt[2*CW +: CW], busy);
        else n_pass++;
    endtask

    task automatic test_packet_lock();
        logic [DW-1:0] b;
        beat_q_t got;
        idle(2);
        exp_q.delete();
        for (int i = 0; i < 4; i++) begin
            b = {$urandom, $urandom};
            exp_q.push_back(b);
            drive((i == 0) ? 2'd1 : 2'd3, b, (i == 3));
            n_checks++;
            if (in_ready !== 1'b1) $display("FAIL lock_in_ready beat=%0d got=%b exp=1", i, in_ready);
            else n_pass++;
            tick();
            n_checks++;
            if (out_valid !== 4'b0010 || port_data(1) !== b)
                $display("FAIL lock_route beat=%0d valid=%b data=%h exp=0010 %h", i, out_valid, port_data(1), b);
            else n_pass++;
            n_checks++;
            if (busy !== (i < 3) || (i < 3 && cur_sel !== 2'd1))
                $display("FAIL lock_busy beat=%0d busy=%b sel=%0d exp=%b/1", i, busy, cur_sel, (i < 3));
            else n_pass++;
        end
        in_valid = 1'b0;
        tick();
        got = port_obs(1);
        n_checks++;
        if (got != exp_q || obs_q.size() != 4)
            $display("FAIL lock_order got_n=%0d all_n=%0d exp_n=4", got.size(), obs_q.size());
        else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] b[3];
        beat_q_t got;
        idle(2);
        for (int i = 0; i < 3; i++) b[i] = {$urandom, $urandom};
        out_ready = 4'b1110;
        drive(2'd0, b[0], 1'b0);
        tick();
        drive(2'd0, b[1], 1'b0);
        for (int c = 0; c < 3; c++) begin
            n_checks++;
            if (in_ready !== 1'b0 || port_data(0) !== b[0] || out_valid[0] !== 1'b1)
                $display("FAIL bp_hold cyc=%0d rdy=%b data=%h exp=0 %h", c, in_ready, port_data(0), b[0]);
            else n_pass++;
            tick();
        end
        out_ready = 4'hF;
        #1;
        for (int i = 1; i < 3; i++) begin
            drive(2'd0, b[i], (i == 2));
            n_checks++;
            if (in_ready !== 1'b1) $display("FAIL bp_flow beat=%0d rdy=%b exp=1", i, in_ready);
            else n_pass++;
            tick();
        end
        in_valid = 1'b0;
        tick();
        got = port_obs(0);
        exp_q = '{b[0], b[1], b[2]};
        n_checks++;
        if (got != exp_q) $display("FAIL bp_sequence got_n=%0d exp_n=3", got.size());
        else n_pass++;
    endtask

    task automatic test_independent_drain();
        logic [DW-1:0] held, b;
        beat_q_t got;
        idle(2);
        held = {$urandom, $urandom};
        out_ready = 4'b0111;
        drive(2'd3, held, 1'b1);
        tick();
        exp_q.delete();
        for (int i = 0; i < 4; i++) begin
            b = {$urandom, $urandom};
            exp_q.push_back(b);
            drive(2'd0, b, (i == 3));
            n_checks++;
            if (in_ready !== 1'b1) $display("FAIL indep_rate beat=%0d rdy=%b exp=1", i, in_ready);
            else n_pass++;
            tick();
            n_checks++;
            if (out_valid[3] !== 1'b1 || port_data(3) !== held)
                $display("FAIL indep_hold beat=%0d v=%b data=%h exp=1 %h", i, out_valid[3], port_data(3), held);
            else n_pass++;
        end
        in_valid  = 1'b0;
        out_ready = 4'hF;
        tick();
        got = port_obs(0);
        n_checks++;
        if (got != exp_q) $display("FAIL indep_port0 got_n=%0d exp_n=4", got.size());
        else n_pass++;
        got = port_obs(3);
        n_checks++;
        if (got.size() != 1 || got[0] !== held) $display("FAIL indep_port3 got_n=%0d exp_n=1", got.size());
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] b;
        idle(2);
        for (int i = 0; i < 2; i++) begin
            drive(2'd1, {$urandom, $urandom}, 1'b0);
            tick();
        end
        reset = 1'b1;
        drive(2'd1, {$urandom, $urandom}, 1'b0);
        tick();
        reset = 1'b0;
        n_checks++;
        if (out_valid !== 4'b0000 || pkt_cnt !== '0 || busy !== 1'b0)
            $display("FAIL rstmid_clear v=%b cnt=%h busy=%b exp=0/0/0", out_valid, pkt_cnt, busy);
        else n_pass++;
        b = {$urandom, $urandom};
        drive(2'd2, b, 1'b0);
        tick();
        n_checks++;
        if (out_valid !== 4'b0100 || port_data(2) !== b || busy !== 1'b1 || cur_sel !== 2'd2)
            $display("FAIL rstmid_route v=%b data=%h busy=%b sel=%0d exp=0100 %h 1 2",
                     out_valid, port_data(2), busy, cur_sel, b);
        else n_pass++;
        drive(2'd0, {$urandom, $urandom}, 1'b1);
        tick();
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 4'b0100 || busy !== 1'b0 || pkt_cnt !== m_cnt_packed())
            $display("FAIL rstmid_end v=%b busy=%b cnt=%h exp=0100 0 %h", out_valid, busy, pkt_cnt, m_cnt_packed());
        else n_pass++;
    endtask

    task automatic test_counter_wrap();
        idle(2);
        for (int i = 0; i < 17; i++) begin
            drive(2'd0, {$urandom, $urandom}, 1'b1);
            tick();
        end
        in_valid = 1'b0;
        n_checks++;
        if (pkt_cnt[0 +: CW] !== 4'd1) $display("FAIL wrap_cnt0 got=%0d exp=1", pkt_cnt[0 +: CW]);
        else n_pass++;
        n_checks++;
        if (pkt_cnt !== m_cnt_packed()) $display("FAIL wrap_all got=%h exp=%h", pkt_cnt, m_cnt_packed());
        else n_pass++;
    endtask

    task automatic test_random();
        bit acc;
        int bad;
        idle(2);
        in_valid = 1'b0;
        for (int c = 0; c < 300; c++) begin
            if (!in_valid && $urandom_range(0, 3) != 0) begin
                in_valid = 1'b1;
                in_sel   = 2'($urandom_range(0, 3));
                in_data  = {$urandom, $urandom};
                in_last  = ($urandom_range(0, 2) == 0);
            end
            out_ready = 4'($urandom_range(0, 15));
            #1;
            n_checks++;
            if (in_ready !== m_ready()) $display("FAIL rand_in_ready cyc=%0d got=%b exp=%b", c, in_ready, m_ready());
            else n_pass++;
            acc = in_valid && m_ready();
            tick();
            bad = 0;
            for (int p = 0; p < 4; p++)
                if (m_valid[p] && (port_data(p) !== m_data[p] || out_last[p] !== m_last[p])) bad++;
            n_checks++;
            if (out_valid !== m_valid || bad != 0)
                $display("FAIL rand_ports cyc=%0d v=%b exp=%b bad_slots=%0d", c, out_valid, m_valid, bad);
            else n_pass++;
            n_checks++;
            if (busy !== m_in_pkt || pkt_cnt !== m_cnt_packed() || (m_in_pkt && int'(cur_sel) != m_lock))
                $display("FAIL rand_state cyc=%0d busy=%b cnt=%h exp=%b %h", c, busy, pkt_cnt, m_in_pkt, m_cnt_packed());
            else n_pass++;
            if (acc) in_valid = 1'b0;
        end
        in_valid = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_sel    = 2'd0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 4'h0;
        model_clear();
        test_reset();
        test_single_beat();
        test_packet_lock();
        test_backpressure();
        test_independent_drain();
        test_reset_mid();
        test_counter_wrap();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/demux4_64b_stream.md
# demux4_64b_stream

Stream demultiplexer that routes 64-bit beats from one upstream valid/ready source to one of four downstream ports. It is the 1-to-4 counterpart of the datapath's 4:1 64-bit select stage. A destination is chosen once per packet and locked until the packet's last beat. Each output port has a one-entry holding register, giving a registered, back-pressure-aware fan-out between pipeline stages.

## Interface
Parameters
- DATA_W, 64, beat width
- CNT_W, 16, per-port packet counter width

Ports
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- in_data  in  DATA_W  upstream beat
- in_sel  in  2  destination port; sampled only on a packet's first beat
- in_last  in  1  marks final beat of packet
- in_valid  in  1  upstream beat present
- in_ready  out  1  block accepts beat this cycle (combinational)
- out_data  out  4*DATA_W  packed; port p at [p*DATA_W +: DATA_W]
- out_last  out  4  per-port last flag
- out_valid  out  4  per-port beat present
- out_ready  in  4  per-port downstream accept
- busy  out  1  1 while a packet is locked (state IN_PKT)
- cur_sel  out  2  locked destination; valid only when busy=1
- pkt_cnt  out  4*CNT_W  packed per-port count of completed packets

## Operation
- State machine:
  - IDLE: destination dest = in_sel.
  - IN_PKT: destination dest = lock_sel; in_sel is ignored.
- A beat is accepted when in_valid & in_ready.
- in_ready = ~out_valid[dest] | out_ready[dest]. A port may accept a new beat in the same cycle it drains.
- In IDLE, in_ready depends combinationally on in_sel. Upstream must hold in_sel stable while in_valid=1.
- Accept in IDLE:
  - in_last=0: lock_sel <= in_sel, go to IN_PKT.
  - in_last=1: single-beat packet; stay in IDLE.
- Accept in IN_PKT:
  - in_last=1: go to IDLE.
  - otherwise: stay in IN_PKT.
- On accept, port dest loads in_data and in_last, and out_valid[dest] is set.
- Port p holding register:
  - out_valid[p] clears when out_valid[p] & out_ready[p] and no new beat loads it in the same cycle.
  - Load and drain in the same cycle: the new beat replaces the old one, and out_valid[p] stays 1.
- Ports not equal to dest are unaffected by input activity. They drain independently.
- Only one port can load per cycle. Beats of one packet never interleave across ports.
- pkt_cnt[p] increments by 1 when a beat with in_last=1 is accepted to port p. It wraps modulo 2^CNT_W.
- out_data and out_last of a port hold their last value when out_valid=0. Their value is don't-care to the bench.

## Timing
- Reset values:
  - state IDLE, busy=0, cur_sel=0, lock_sel=0
  - out_valid=0, out_data=0, out_last=0
  - pkt_cnt=0
- in_ready is not forced low by reset. It follows the equation, so it is 1 the cycle after reset.
- Latency: a beat accepted at edge N is visible on port dest (out_valid=1) after edge N, i.e. 1 cycle.
- Throughput: 1 beat/cycle sustained to a port whose out_ready is held 1.
- Back-pressure: out_valid[dest]=1 & out_ready[dest]=0 forces in_ready=0. The held beat and its data are stable until drained.
- Reset mid-packet: all holding registers are cleared and the in-flight packet is dropped. The next accepted beat is treated as a first beat.
- Simultaneous drain on port p and load to port q≠p: both take effect on the same edge.
- Reset asserted with in_valid=1: nothing is accepted that cycle.

## Test plan
- Single-beat packet: in_sel=2, in_data=64'hDEADBEEF_00000001, in_last=1, out_ready=4'hF.
  - Required: out_valid=4'b0100 one cycle later with matching data and out_last[2]=1.
  - Required: pkt_cnt[2]=1, busy stays 0.
- Packet lock: a 4-beat packet starts with in_sel=1; in_sel is changed to 3 on beats 2–4.
  - Required: all 4 beats appear only on port 1, in order.
  - Required: busy=1 and cur_sel=1 from after beat 1 until after beat 4.
- Back-pressure: out_ready[0]=0 during a 3-beat packet to port 0.
  - Required: beat 1 is held stable on port 0 and in_ready=0 from the next cycle.
  - Required: after out_ready[0]=1, the remaining beats flow 1/cycle with no loss or duplication.
- Independent drain: port 3 holds a beat with out_ready[3]=0 while a packet streams to port 0.
  - Required: port 0 streams at full rate.
  - Required: port 3 data is unchanged until out_ready[3]=1.
- Reset mid-packet: reset is asserted after beat 2 of a 5-beat packet to port 1.
  - Required: out_valid=0, pkt_cnt=0, busy=0 the next cycle.
  - Required: a new packet with in_sel=2 routes to port 2.
- Counter wrap: with CNT_W=4, send 17 single-beat packets to port 0.
  - Required: pkt_cnt[0]=1.
